// File: rtl/cdb_requester_pkg.sv
// Shared CDB definitions: bus widths and the broadcast entry layout that the
// reservation stations snooping the CDB reuse.
package cdb_pkg;

    localparam int CDB_TAG_WIDTH  = 6;
    localparam int CDB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [CDB_TAG_WIDTH-1:0]  tag;
        logic [CDB_DATA_WIDTH-1:0] data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_requester_if.sv
// Result-in / arbiter handshake / CDB-out signal bundle for one requester leaf.
interface cdb_requester_if
    import cdb_pkg::*;
#(
    parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
    parameter int DATA_WIDTH = CDB_DATA_WIDTH
);
    logic                  result_valid_IN;
    logic [TAG_WIDTH-1:0]  result_tag_IN;
    logic [DATA_WIDTH-1:0] result_data_IN;
    logic                  stall_OUT;
    logic                  flush_IN;
    logic                  request_OUT;
    logic                  grant_IN;
    logic                  cdb_valid_OUT;
    logic [TAG_WIDTH-1:0]  cdb_tag_OUT;
    logic [DATA_WIDTH-1:0] cdb_data_OUT;

    // master: the requester itself
    modport master (
        input  result_valid_IN, result_tag_IN, result_data_IN, flush_IN, grant_IN,
        output stall_OUT, request_OUT, cdb_valid_OUT, cdb_tag_OUT, cdb_data_OUT
    );

    // slave: functional unit, arbiter slot and CDB listeners
    modport slave (
        output result_valid_IN, result_tag_IN, result_data_IN, flush_IN, grant_IN,
        input  stall_OUT, request_OUT, cdb_valid_OUT, cdb_tag_OUT, cdb_data_OUT
    );
endinterface

// File: rtl/cdb_requester_result_fifo.sv
// Synchronous result FIFO with flush; head entry is visible combinationally on rdata.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage carries no reset; only pointers/count define what is live.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/cdb_requester.sv
// CDB requester leaf: buffers FU results, requests an arbiter slot, and
// broadcasts the granted head entry one cycle after grant.
module cdb_requester
    import cdb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
    parameter int DATA_WIDTH = CDB_DATA_WIDTH
) (
    input  logic              clk_IN,
    input  logic              reset_IN,
    cdb_requester_if.master   bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           wr_entry;
    entry_t           head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign wr_entry    = '{tag: bus.result_tag_IN, data: bus.result_data_IN};
    assign push        = bus.result_valid_IN && !full && !bus.flush_IN;
    assign bus.request_OUT = !empty && !bus.flush_IN && !reset_IN;
    assign pop         = bus.grant_IN && bus.request_OUT;
    assign bus.stall_OUT   = full;

    result_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk_IN),
        .rst   (reset_IN),
        .flush (bus.flush_IN),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Tag/data forced to zero when idle so multiple leaves can be OR-combined.
    always_ff @(posedge clk_IN) begin
        if (reset_IN || !pop) begin
            bus.cdb_valid_OUT <= 1'b0;
            bus.cdb_tag_OUT   <= '0;
            bus.cdb_data_OUT  <= '0;
        end else begin
            bus.cdb_valid_OUT <= 1'b1;
            bus.cdb_tag_OUT   <= head.tag;
            bus.cdb_data_OUT  <= head.data;
        end
    end

    logic unused_count;
    assign unused_count = ^count;
endmodule

// File: tb/tb_cdb_requester.sv
// Scoreboard bench for cdb_requester: queue reference model, directed plan then random traffic.
module tb_cdb_requester;
    import cdb_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic       v;
        cdb_entry_t e;
    } exp_t;

    logic clk = 1'b0;
    logic reset_IN;
    always #5 clk = ~clk;

    cdb_requester_if #(.TAG_WIDTH(CDB_TAG_WIDTH), .DATA_WIDTH(CDB_DATA_WIDTH)) bus ();

    cdb_requester #(.DEPTH(DEPTH)) dut (
        .clk_IN   (clk),
        .reset_IN (reset_IN),
        .bus      (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int violations = 0;
    bit started = 0;

    cdb_entry_t mq[$];   // reference FIFO contents
    exp_t       sb[$];   // expected CDB output per cycle

    // Reference model: evaluated on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        exp_t x;
        bit   req;
        bit   stall;
        x       = '0;
        started = 1;
        stall   = (mq.size() == DEPTH);
        req     = (mq.size() != 0) && !bus.flush_IN && !reset_IN;
        if (reset_IN || bus.flush_IN) begin
            mq.delete();
        end else begin
            if (bus.result_valid_IN && stall) violations++;
            if (bus.grant_IN && req) begin
                x.v = 1'b1;
                x.e = mq.pop_front();
            end
            if (bus.result_valid_IN && !stall)
                mq.push_back('{tag: bus.result_tag_IN, data: bus.result_data_IN});
        end
        sb.push_back(x);
    end

    // Monitor: compares away from the active edge.
    always @(negedge clk) begin
        exp_t x;
        bit   req_exp;
        if (started) begin
            req_exp = (mq.size() != 0) && !bus.flush_IN && !reset_IN;
            total++;
            if (bus.request_OUT !== req_exp) begin
                bad++;
                $display("FAIL request t=%0t got=%b exp=%b", $time, bus.request_OUT, req_exp);
            end
            total++;
            if (bus.stall_OUT !== (mq.size() == DEPTH)) begin
                bad++;
                $display("FAIL stall t=%0t got=%b exp=%b", $time, bus.stall_OUT, mq.size() == DEPTH);
            end
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            total++;
            if (bus.cdb_valid_OUT !== x.v || bus.cdb_tag_OUT !== x.e.tag || bus.cdb_data_OUT !== x.e.data) begin
                bad++;
                $display("FAIL cdb t=%0t got=%b/%0d/%h exp=%b/%0d/%h", $time,
                         bus.cdb_valid_OUT, bus.cdb_tag_OUT, bus.cdb_data_OUT,
                         x.v, x.e.tag, x.e.data);
            end
        end
    end

    task automatic step(input bit v, input int tag, input logic [31:0] data,
                        input bit g, input bit f, input bit r);
        bus.result_valid_IN = v;
        bus.result_tag_IN   = CDB_TAG_WIDTH'(tag);
        bus.result_data_IN  = data;
        bus.grant_IN        = g;
        bus.flush_IN        = f;
        reset_IN            = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // single push, one-cycle request latency, grant-to-broadcast latency
        step(1, 5, 32'h1234, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        // fill to stall, dropped 5th push, drain back-to-back
        for (int i = 1; i <= 4; i++) step(1, i, 32'hA000 + i, 0, 0, 0);
        step(1, 9, 32'h9999, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        idle(2);
        // simultaneous push+pop at count 2, then wrap the pointers
        step(1, 10, 32'h10, 0, 0, 0);
        step(1, 11, 32'h11, 0, 0, 0);
        step(1, 7, 32'h7, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 20 + i, 32'h200 + i, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        // grant with empty FIFO
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // flush at count 3 while a broadcast is already registered
        for (int i = 0; i < 4; i++) step(1, 30 + i, 32'h300 + i, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 40, 32'h400, 1, 1, 0);
        idle(2);
        // reset mid-drain at count 2, then run as from power-up
        for (int i = 0; i < 3; i++) step(1, 50 + i, 32'h500 + i, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        step(1, 5, 32'h1234, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        // random traffic; FU honours stall
        for (int i = 0; i < 3000; i++) begin
            bit v;
            v = ($urandom_range(99) < 60) && (mq.size() != DEPTH);
            step(v, $urandom_range(63), $urandom,
                 $urandom_range(99) < 45,
                 $urandom_range(99) < 3,
                 $urandom_range(999) < 5);
        end
        idle(3);
        total++;
        if (violations != 1) begin
            bad++;
            $display("FAIL stall_violations got=%0d exp=1", violations);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
